// File: rtl/biriscv_branch_unit.sv
// biriscv_branch_unit: pipelined branch resolution for the biRISC-V execute stage.
//
// Decodes JAL/JALR/Bxx, computes the target in stage 1 and resolves the
// condition in the final stage. Results appear one cycle later as
// single-cycle pulses on branch_* and are pushed into a resolution FIFO.
//
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   opcode_*                instruction input (valid/ready, word, pc, regs)
//   hold_i / flush_i        pipeline freeze / kill of in-flight branches
//   branch_*                resolved branch pulse to fetch/BPU
//   res_valid_o/accept_i    resolution FIFO head handshake
//   res_data_o              {taken, call, ret, jmp, source, target}
//   mispredict_o            misprediction pulse (0 unless the macro is set)
//
// Optional build macro: BRANCH_UNIT_MISPREDICT_EN adds opcode_pred_taken_i
// and opcode_pred_pc_i; branch_request_o then fires only on a mispredict.

module biriscv_branch_unit #(
    parameter int PIPE_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int FIFO_AW     = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        opcode_valid_i,
    output logic        opcode_ready_o,
    input  logic [31:0] opcode_opcode_i,
    input  logic [31:0] opcode_pc_i,
    input  logic [4:0]  opcode_rd_idx_i,
    input  logic [4:0]  opcode_ra_idx_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
`ifdef BRANCH_UNIT_MISPREDICT_EN
    input  logic        opcode_pred_taken_i,
    input  logic [31:0] opcode_pred_pc_i,
`endif

    input  logic        hold_i,
    input  logic        flush_i,

    output logic        branch_request_o,
    output logic        branch_is_taken_o,
    output logic        branch_is_not_taken_o,
    output logic [31:0] branch_source_o,
    output logic [31:0] branch_pc_o,
    output logic        branch_is_call_o,
    output logic        branch_is_ret_o,
    output logic        branch_is_jmp_o,

    output logic        res_valid_o,
    input  logic        res_accept_i,
    output logic [67:0] res_data_o,

    output logic        mispredict_o
);

    // Credit counter is wide enough for FIFO_DEPTH plus the pipeline.
    localparam int CW = FIFO_AW + 2;

    typedef struct packed {
        logic        valid;
        logic        is_br;
        logic        call;
        logic        ret;
        logic        jmp;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] target;
        logic [31:0] ra;
        logic [31:0] rb;
`ifdef BRANCH_UNIT_MISPREDICT_EN
        logic        pred_taken;
        logic [31:0] pred_pc;
`endif
    } stage_t;

    typedef struct packed {
        logic        req;
        logic        taken;
        logic        not_taken;
        logic        call;
        logic        ret;
        logic        jmp;
        logic [31:0] source;
        logic [31:0] pc;
`ifdef BRANCH_UNIT_MISPREDICT_EN
        logic        misp;
`endif
    } out_t;

    // ------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        is_jal;
    logic        is_jalr;
    logic        is_bxx;
    logic        accept;
    logic [31:0] jimm;
    logic [31:0] bimm;
    logic [31:0] iimm;
    logic [31:0] jalr_sum;
    stage_t      dec;

    assign op = opcode_opcode_i[6:0];
    assign f3 = opcode_opcode_i[14:12];

    assign jimm = {{11{opcode_opcode_i[31]}}, opcode_opcode_i[31],
                   opcode_opcode_i[19:12], opcode_opcode_i[20],
                   opcode_opcode_i[30:21], 1'b0};
    assign bimm = {{19{opcode_opcode_i[31]}}, opcode_opcode_i[31],
                   opcode_opcode_i[7], opcode_opcode_i[30:25],
                   opcode_opcode_i[11:8], 1'b0};
    assign iimm = {{20{opcode_opcode_i[31]}}, opcode_opcode_i[31:20]};

    assign jalr_sum = opcode_ra_operand_i + iimm;

    always_comb begin
        is_jal  = (op == 7'b1101111);
        is_jalr = (op == 7'b1100111) && (f3 == 3'b000);
        // funct3 010/011 are unused encodings under BRANCH
        is_bxx  = (op == 7'b1100011) && (f3 != 3'b010) && (f3 != 3'b011);
    end

    assign accept = opcode_valid_i & opcode_ready_o & ~hold_i & ~flush_i;

    always_comb begin
        dec        = '0;
        dec.valid  = accept & (is_jal | is_jalr | is_bxx);
        dec.is_br  = is_bxx;
        dec.f3     = f3;
        dec.pc     = opcode_pc_i;
        dec.pc4    = opcode_pc_i + 32'd4;
        dec.ra     = opcode_ra_operand_i;
        dec.rb     = opcode_rb_operand_i;
`ifdef BRANCH_UNIT_MISPREDICT_EN
        dec.pred_taken = opcode_pred_taken_i;
        dec.pred_pc    = opcode_pred_pc_i;
`endif
        unique case (1'b1)
            is_jal: begin
                dec.target = opcode_pc_i + jimm;
                dec.call   = (opcode_rd_idx_i == 5'd1);
                dec.jmp    = 1'b1;
            end
            is_jalr: begin
                dec.target = {jalr_sum[31:1], 1'b0};
                dec.ret    = (opcode_ra_idx_i == 5'd1) &&
                             (opcode_opcode_i[31:20] == 12'd0);
                dec.call   = ~dec.ret & (opcode_rd_idx_i == 5'd1);
                dec.jmp    = ~(dec.call | dec.ret);
            end
            is_bxx: begin
                dec.target = opcode_pc_i + bimm;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------
    // Pipeline: stage 0 registers the decode, the rest only delay
    // ------------------------------------------------------------
    stage_t st_q [PIPE_STAGES];
    stage_t st_d [PIPE_STAGES];

    always_comb begin
        st_d = st_q;
        if (flush_i) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                st_d[i].valid = 1'b0;
            end
        end else if (!hold_i) begin
            st_d[0] = dec;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                st_d[i] = st_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------
    // Final-stage resolution
    // ------------------------------------------------------------
    stage_t last;
    logic   cond;
    logic   taken;
    logic   fire;
    out_t   out_d;
    out_t   out_q;

    assign last = st_q[PIPE_STAGES-1];

    always_comb begin
        cond = 1'b0;
        case (last.f3)
            3'b000:  cond = (last.ra == last.rb);
            3'b001:  cond = (last.ra != last.rb);
            3'b100:  cond = ($signed(last.ra) <  $signed(last.rb));
            3'b101:  cond = ($signed(last.ra) >= $signed(last.rb));
            3'b110:  cond = (last.ra <  last.rb);
            3'b111:  cond = (last.ra >= last.rb);
            default: cond = 1'b0;
        endcase
    end

    assign taken = last.is_br ? cond : 1'b1;

    // A held or flushed final stage neither pulses nor pushes
    assign fire = last.valid & ~hold_i & ~flush_i;

    always_comb begin
        out_d = '0;
        if (fire) begin
            out_d.taken     = taken;
            out_d.not_taken = ~taken;
            out_d.call      = last.call;
            out_d.ret       = last.ret;
            out_d.jmp       = last.jmp;
            out_d.source    = last.pc;
            out_d.pc        = taken ? last.target : last.pc4;
`ifdef BRANCH_UNIT_MISPREDICT_EN
            out_d.misp      = (last.pred_taken != taken) |
                              (taken & (last.pred_pc != last.target));
            out_d.req       = out_d.misp;
`else
            out_d.req       = 1'b1;
`endif
        end
    end

    assign branch_request_o      = out_q.req;
    assign branch_is_taken_o     = out_q.taken;
    assign branch_is_not_taken_o = out_q.not_taken;
    assign branch_source_o       = out_q.source;
    assign branch_pc_o           = out_q.pc;
    assign branch_is_call_o      = out_q.call;
    assign branch_is_ret_o       = out_q.ret;
    assign branch_is_jmp_o       = out_q.jmp;
`ifdef BRANCH_UNIT_MISPREDICT_EN
    assign mispredict_o          = out_q.misp;
`else
    assign mispredict_o          = 1'b0;
`endif

    // ------------------------------------------------------------
    // Resolution FIFO
    // ------------------------------------------------------------
    logic [67:0]        mem_q [FIFO_DEPTH];
    logic [67:0]        mem_d [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_d;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;
    logic               push;
    logic               pop;
    logic [67:0]        entry;

    assign push  = fire;
    assign pop   = res_accept_i & (count_q != '0);
    assign entry = {taken, last.call, last.ret, last.jmp,
                    last.pc, last.target};

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Credits guarantee room, so push never checks for full
        if (push) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
            default: ;
        endcase
    end

    assign res_valid_o = (count_q != '0);
    assign res_data_o  = mem_q[rd_ptr_q];

    // ------------------------------------------------------------
    // Credits: branches in the pipe plus entries waiting in the FIFO
    // ------------------------------------------------------------
    logic [CW-1:0] credit_q;
    logic [CW-1:0] credit_d;
    logic [CW-1:0] inflight;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            inflight = inflight + CW'(st_d[i].valid);
        end
        credit_d = inflight + CW'(count_d);
    end

    assign opcode_ready_o = (credit_q < CW'(FIFO_DEPTH));

    // ------------------------------------------------------------
    // State
    // ------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                st_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            out_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            credit_q <= '0;
        end else begin
            st_q     <= st_d;
            mem_q    <= mem_d;
            out_q    <= out_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
        end
    end

endmodule

// File: tb/tb_biriscv_branch_unit.sv
// tb_biriscv_branch_unit: vector table plus hand sequences for latency,
// flush, hold, FIFO credit back-pressure and asynchronous reset.

module tb_biriscv_branch_unit;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        opcode_valid_i;
    logic        opcode_ready_o;
    logic [31:0] opcode_opcode_i;
    logic [31:0] opcode_pc_i;
    logic [4:0]  opcode_rd_idx_i;
    logic [4:0]  opcode_ra_idx_i;
    logic [31:0] opcode_ra_operand_i;
    logic [31:0] opcode_rb_operand_i;
    logic        hold_i;
    logic        flush_i;
    logic        branch_request_o;
    logic        branch_is_taken_o;
    logic        branch_is_not_taken_o;
    logic [31:0] branch_source_o;
    logic [31:0] branch_pc_o;
    logic        branch_is_call_o;
    logic        branch_is_ret_o;
    logic        branch_is_jmp_o;
    logic        res_valid_o;
    logic        res_accept_i;
    logic [67:0] res_data_o;
    logic        mispredict_o;

    biriscv_branch_unit #(
        .PIPE_STAGES(2),
        .FIFO_DEPTH (4),
        .FIFO_AW    (2)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .opcode_valid_i       (opcode_valid_i),
        .opcode_ready_o       (opcode_ready_o),
        .opcode_opcode_i      (opcode_opcode_i),
        .opcode_pc_i          (opcode_pc_i),
        .opcode_rd_idx_i      (opcode_rd_idx_i),
        .opcode_ra_idx_i      (opcode_ra_idx_i),
        .opcode_ra_operand_i  (opcode_ra_operand_i),
        .opcode_rb_operand_i  (opcode_rb_operand_i),
        .hold_i               (hold_i),
        .flush_i              (flush_i),
        .branch_request_o     (branch_request_o),
        .branch_is_taken_o    (branch_is_taken_o),
        .branch_is_not_taken_o(branch_is_not_taken_o),
        .branch_source_o      (branch_source_o),
        .branch_pc_o          (branch_pc_o),
        .branch_is_call_o     (branch_is_call_o),
        .branch_is_ret_o      (branch_is_ret_o),
        .branch_is_jmp_o      (branch_is_jmp_o),
        .res_valid_o          (res_valid_o),
        .res_accept_i         (res_accept_i),
        .res_data_o           (res_data_o),
        .mispredict_o         (mispredict_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        br;
        logic        tk;
        logic        call;
        logic        ret;
        logic        jmp;
        logic [31:0] npc;
        logic [31:0] tgt;
    } vec_t;

    typedef struct {
        logic        tk;
        logic        call;
        logic        ret;
        logic        jmp;
        logic [31:0] src;
        logic [31:0] npc;
    } exp_t;

    exp_t        exp_q[$];
    logic [67:0] res_q[$];
    int          total = 0;
    int          bad = 0;
    exp_t        mon_e;

    task automatic chk(input string nm, input logic [67:0] got,
                       input logic [67:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3,
                                          input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11],
                7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd,
                                            input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd,
                                             input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic vec_t mk(
        input logic [31:0] op, input logic [31:0] pc,
        input logic [4:0] rd, input logic [4:0] rs1,
        input logic [31:0] ra, input logic [31:0] rb,
        input logic br, input logic tk, input logic call,
        input logic ret, input logic jmp,
        input logic [31:0] npc, input logic [31:0] tgt);
        vec_t v;
        v.op = op; v.pc = pc; v.rd = rd; v.rs1 = rs1;
        v.ra = ra; v.rb = rb; v.br = br; v.tk = tk;
        v.call = call; v.ret = ret; v.jmp = jmp;
        v.npc = npc; v.tgt = tgt;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction until accepted; expectations are queued
    // only for branches that should survive to the outputs.
    task automatic send(input vec_t v, input bit expect_out);
        int   w;
        exp_t e;
        w = 0;
        opcode_opcode_i     = v.op;
        opcode_pc_i         = v.pc;
        opcode_rd_idx_i     = v.rd;
        opcode_ra_idx_i     = v.rs1;
        opcode_ra_operand_i = v.ra;
        opcode_rb_operand_i = v.rb;
        opcode_valid_i      = 1'b1;
        while (!opcode_ready_o && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=ready0 want=ready1 pc=%h",
                     v.pc);
        end
        if (expect_out) begin
            e.tk = v.tk; e.call = v.call; e.ret = v.ret; e.jmp = v.jmp;
            e.src = v.pc; e.npc = v.npc;
            exp_q.push_back(e);
            res_q.push_back({v.tk, v.call, v.ret, v.jmp, v.pc, v.tgt});
        end
        tick();
        opcode_valid_i = 1'b0;
    endtask

    // Scoreboard: branch pulses and FIFO pops checked against queues
    always @(negedge clk) begin
        if (rst_ni) begin
            if (branch_request_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse got src=%h want none",
                             branch_source_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse",
                        {branch_is_taken_o, branch_is_not_taken_o,
                         branch_is_call_o, branch_is_ret_o,
                         branch_is_jmp_o, branch_source_o, branch_pc_o},
                        {mon_e.tk, ~mon_e.tk, mon_e.call, mon_e.ret,
                         mon_e.jmp, mon_e.src, mon_e.npc});
                    chk("mispredict", mispredict_o, 0);
                end
            end
            if (res_valid_o && res_accept_i) begin
                if (res_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_res got=%h want none",
                             res_data_o);
                end else begin
                    chk("res_data", res_data_o, res_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[14];
        vec_t v;

        vt[0]  = mk(enc_b(3'd0, 13'h0020), 32'h100, 5'd0, 5'd1,
                    32'd5, 32'd5, 1, 1, 0, 0, 0, 32'h120, 32'h120);
        vt[1]  = mk(enc_b(3'd1, 13'h0040), 32'h200, 5'd0, 5'd1,
                    32'd5, 32'd5, 1, 0, 0, 0, 0, 32'h204, 32'h240);
        vt[2]  = mk(enc_b(3'd4, 13'h1FF8), 32'h300, 5'd0, 5'd1,
                    32'hFFFFFFFF, 32'd1, 1, 1, 0, 0, 0, 32'h2F8, 32'h2F8);
        vt[3]  = mk(enc_b(3'd6, 13'h0010), 32'h400, 5'd0, 5'd1,
                    32'hFFFFFFFF, 32'd1, 1, 0, 0, 0, 0, 32'h404, 32'h410);
        vt[4]  = mk(enc_b(3'd5, 13'h0100), 32'h500, 5'd0, 5'd1,
                    32'd1, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 32'h600, 32'h600);
        vt[5]  = mk(enc_b(3'd7, 13'h0008), 32'h600, 5'd0, 5'd1,
                    32'd1, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 32'h604, 32'h608);
        vt[6]  = mk(enc_jalr(5'd0, 5'd1, 12'h000), 32'h700, 5'd0, 5'd1,
                    32'h2003, 32'd0, 1, 1, 0, 1, 0, 32'h2002, 32'h2002);
        vt[7]  = mk(enc_jal(5'd1, 21'h000800), 32'h800, 5'd1, 5'd0,
                    32'd0, 32'd0, 1, 1, 1, 0, 1, 32'h1000, 32'h1000);
        vt[8]  = mk(enc_jalr(5'd1, 5'd5, 12'h010), 32'h900, 5'd1, 5'd5,
                    32'h3000, 32'd0, 1, 1, 1, 0, 0, 32'h3010, 32'h3010);
        vt[9]  = mk(enc_jal(5'd0, 21'h1FFFFC), 32'hA00, 5'd0, 5'd0,
                    32'd0, 32'd0, 1, 1, 0, 0, 1, 32'h9FC, 32'h9FC);
        vt[10] = mk(32'h00500093, 32'hA10, 5'd1, 5'd0,
                    32'd0, 32'd0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        vt[11] = mk(enc_b(3'd2, 13'h0020), 32'hA20, 5'd0, 5'd1,
                    32'd5, 32'd5, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        vt[12] = mk(enc_b(3'd0, 13'h0020), 32'hFFFFFFF0, 5'd0, 5'd1,
                    32'd0, 32'd0, 1, 1, 0, 0, 0, 32'h10, 32'h10);
        vt[13] = mk(enc_jalr(5'd0, 5'd1, 12'h004), 32'hB00, 5'd0, 5'd1,
                    32'h100, 32'd0, 1, 1, 0, 0, 1, 32'h104, 32'h104);

        rst_ni = 1'b0;
        opcode_valid_i = 1'b0;
        opcode_opcode_i = '0;
        opcode_pc_i = '0;
        opcode_rd_idx_i = '0;
        opcode_ra_idx_i = '0;
        opcode_ra_operand_i = '0;
        opcode_rb_operand_i = '0;
        hold_i = 1'b0;
        flush_i = 1'b0;
        res_accept_i = 1'b0;
        #1;
        chk("rst_ready", opcode_ready_o, 1);
        chk("rst_req", branch_request_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_misp", mispredict_o, 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        tick();

        // Latency: BEQ pulse exactly two cycles after accept
        send(vt[0], 1);
        chk("lat_c0", branch_request_o, 0);
        tick();
        chk("lat_c1", branch_request_o, 0);
        tick();
        chk("lat_c2",
            {branch_request_o, branch_is_taken_o, branch_pc_o,
             branch_source_o, res_valid_o},
            {1'b1, 1'b1, 32'h120, 32'h100, 1'b1});
        res_accept_i = 1'b1;
        tick();

        // Vector table, back to back
        for (int i = 0; i < 14; i++) begin
            send(vt[i], vt[i].br);
        end
        repeat (6) tick();
        chk("table_pulses_left", exp_q.size(), 0);
        chk("table_res_left", res_q.size(), 0);

        // Flush with two branches in flight
        v = mk(enc_b(3'd1, 13'h0040), 32'hC00, 5'd0, 5'd1,
               32'd1, 32'd2, 1, 1, 0, 0, 0, 32'hC40, 32'hC40);
        send(v, 0);
        v.pc = 32'hC10;
        send(v, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (4) tick();
        chk("flush_res_valid", res_valid_o, 0);

        // Hold for three cycles with one branch in stage 1
        v = mk(enc_jal(5'd1, 21'h000100), 32'hD00, 5'd1, 5'd0,
               32'd0, 32'd0, 1, 1, 1, 0, 1, 32'hE00, 32'hE00);
        send(v, 1);
        hold_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_quiet", branch_request_o, 0);
        end
        hold_i = 1'b0;
        repeat (4) tick();
        chk("hold_emitted", exp_q.size(), 0);

        // Credits: four accepts fill, the fifth waits for a pop
        res_accept_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v = mk(enc_b(3'd1, 13'h0040), 32'h1000 + 32'(k) * 32'h10,
                   5'd0, 5'd1, 32'd1, 32'd2, 1, 1, 0, 0, 0,
                   32'h1040 + 32'(k) * 32'h10,
                   32'h1040 + 32'(k) * 32'h10);
            if (k == 3) chk("ready_before_4th", opcode_ready_o, 1);
            send(v, 1);
        end
        chk("ready_drop", opcode_ready_o, 0);
        repeat (4) tick();
        chk("ready_full", opcode_ready_o, 0);
        chk("full_res_valid", res_valid_o, 1);
        res_accept_i = 1'b1;
        tick();
        res_accept_i = 1'b0;
        chk("ready_after_pop", opcode_ready_o, 1);
        v = mk(enc_b(3'd1, 13'h0040), 32'h1040, 5'd0, 5'd1,
               32'd1, 32'd2, 1, 1, 0, 0, 0, 32'h1080, 32'h1080);
        send(v, 1);
        repeat (4) tick();
        res_accept_i = 1'b1;
        repeat (6) tick();
        chk("drain_res_valid", res_valid_o, 0);
        chk("drain_res_left", res_q.size(), 0);
        chk("drain_pulses_left", exp_q.size(), 0);

        // Asynchronous reset mid-stream
        res_accept_i = 1'b0;
        v = mk(enc_b(3'd0, 13'h0008), 32'h40, 5'd0, 5'd1,
               32'd0, 32'd0, 1, 1, 0, 0, 0, 32'h48, 32'h48);
        send(v, 1);
        v.pc = 32'h50; v.npc = 32'h58; v.tgt = 32'h58;
        send(v, 1);
        repeat (3) tick();
        v.pc = 32'h60; v.npc = 32'h68; v.tgt = 32'h68;
        send(v, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_ready", opcode_ready_o, 1);
        chk("mid_rst_outs",
            {branch_request_o, branch_is_taken_o, branch_is_not_taken_o,
             branch_pc_o, branch_source_o, res_valid_o},
            0);
        chk("mid_rst_res_data", res_data_o, 0);
        exp_q.delete();
        res_q.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        res_accept_i = 1'b1;
        v = mk(enc_jal(5'd1, 21'h000100), 32'h2000, 5'd1, 5'd0,
               32'd0, 32'd0, 1, 1, 1, 0, 1, 32'h2100, 32'h2100);
        send(v, 1);
        repeat (6) tick();
        chk("post_rst_pulses_left", exp_q.size(), 0);
        chk("post_rst_res_left", res_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/biriscv_branch_unit.md
Name: biriscv_branch_unit

Overview:
- Parametrised, pipelined branch resolution unit for the biRISC-V execute stage. Successor to the single-stage branch logic inside the exec block.
- Decodes JAL/JALR/Bxx, computes targets, and resolves conditions over a configurable number of pipeline stages.
- Drives one-cycle branch pulses to fetch/BPU and queues resolution records in a credit-guarded FIFO for the BTB/BHT update path.

Parameters:
- PIPE_STAGES, 2, compare latency in cycles; legal 1..4.
- FIFO_DEPTH, 4, resolution-queue entries; power of two, 2..16.
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- opcode_valid_i  in  1  instruction valid
- opcode_ready_o  out  1  unit can accept (credit available)
- opcode_opcode_i  in  32  instruction word
- opcode_pc_i  in  32  instruction PC
- opcode_rd_idx_i  in  5  rd
- opcode_ra_idx_i  in  5  rs1
- opcode_ra_operand_i  in  32  rs1 value
- opcode_rb_operand_i  in  32  rs2 value
- hold_i  in  1  pipeline freeze
- flush_i  in  1  kill in-flight instructions
- branch_request_o  out  1  resolved branch pulse
- branch_is_taken_o  out  1  taken
- branch_is_not_taken_o  out  1  not taken
- branch_source_o  out  32  branch PC
- branch_pc_o  out  32  next PC (target or PC+4)
- branch_is_call_o / branch_is_ret_o / branch_is_jmp_o  out  1 each  type flags
- res_valid_o  out  1  queue head valid
- res_accept_i  in  1  consumer pops head
- res_data_o  out  68  {taken, call, ret, jmp, source[31:0], target[31:0]}
- mispredict_o  out  1  see Optional Feature

Behaviour:
- Reset: all pipeline valids, FIFO pointers/count and credit counter = 0. All outputs 0, except opcode_ready_o = 1.
- Accept: accept = opcode_valid_i & opcode_ready_o & ~hold_i & ~flush_i.
- Non-branch instructions are accepted, consume no credit and produce no output.
- Decode is on opcode[6:0] and funct3: JAL 1101111; JALR 1100111/f3=0; BRANCH 1100011 with f3 in {0,1,4,5,6,7}. Any other funct3 under BRANCH is treated as non-branch.
- Stage 1 registers operands, type flags, PC+4 and the target:
  - JAL: pc+jimm20.
  - JALR: (ra+imm12) with bit0 forced to 0.
  - Bxx: pc+bimm.
  - Arithmetic is 32-bit modulo; wrap-around is ignored.
- Type flags:
  - JAL: call = (rd==1), jmp = 1.
  - JALR: ret = (rs1==1 & imm12==0); call = ~ret & (rd==1); jmp = ~(call|ret).
  - Bxx: all flags 0.
- Condition:
  - Evaluated in the final stage: EQ, NE, signed LT/GE, unsigned LTU/GEU.
  - JAL/JALR are always taken.
  - Stages 2..PIPE_STAGES are pure delay registers.
- Latency: an instruction accepted at edge N drives branch_* outputs for exactly one cycle after edge N+PIPE_STAGES. It is pushed to the FIFO on that same edge.
  - branch_pc_o = taken ? target : pc+4.
  - branch_request_o = taken | not_taken.
  - Outputs are 0 when the final stage is invalid.
- hold_i: freezes all pipeline stages. The FIFO pop still operates. branch_* outputs hold 0 while hold_i = 1. The result is emitted once after hold_i deasserts.
- flush_i: clears every pipeline valid on the next edge and returns their credits. A result in the final stage on the flush cycle is suppressed (neither pulsed nor pushed). FIFO contents are kept.
- Credit: credits = in-flight branches + FIFO count. opcode_ready_o = (credits < FIFO_DEPTH), so a push never finds the FIFO full.
- Simultaneous push and pop: count unchanged, including when full.
- Pop with an empty FIFO: ignored.
- res_data_o is the head entry; its value is undefined when res_valid_o = 0.
- Reset mid-operation: everything returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: BRANCH_UNIT_MISPREDICT_EN.
- When defined:
  - Adds inputs opcode_pred_taken_i (1) and opcode_pred_pc_i (32), pipelined alongside the instruction.
  - mispredict_o pulses with branch_request_o when (pred_taken != taken) or (taken & pred_pc != target).
  - branch_request_o is then asserted only on a mispredict; branch_is_* flags are still driven as normal.
  - The FIFO still records every branch.
- When undefined: the prediction ports are absent, mispredict_o = 0, and behaviour is as above.

Test Plan:
- Reset: rst_ni = 0 mid-stream -> all outputs 0, opcode_ready_o = 1, res_valid_o = 0; operation resumes cleanly after release.
- BEQ at pc 0x100 (bimm = +0x20), ra = rb = 5, PIPE_STAGES = 2 -> two cycles after accept, branch_is_taken_o = 1, branch_pc_o = 0x120, branch_source_o = 0x100, res_valid_o = 1.
- BLT with ra = 0xFFFFFFFF, rb = 1 -> taken. BLTU with the same operands -> not taken, branch_pc_o = pc+4.
- JALR rd = 0, rs1 = 1, imm = 0, ra = 0x2003 -> taken, target 0x2002, ret = 1, call = 0, jmp = 0. JAL rd = 1 -> call = 1, jmp = 1.
- FIFO_DEPTH = 4, res_accept_i = 0, five back-to-back BNE-taken -> opcode_ready_o drops after the 4th accept. The 5th is accepted only after a pop. No entry is lost; pops return entries in order.
- flush_i while 2 branches are in flight, plus hold_i = 1 for 3 cycles on another branch -> flushed branches never appear and their credits return; the held branch is emitted exactly once after release.
